// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped byte FIFO feeding an 8N1 UART transmitter
module io_uart_tx #(
  parameter int              CLKS_PER_BIT = 868,
  parameter int              FIFO_DEPTH   = 16,
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR    = ADDR_W'(32'h0003_0000)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        io_we,
  input  logic [ADDR_W-1:0]           io_addr,
  input  logic [7:0]                  io_wdata,
  output logic                        io_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        tx_busy,
  output logic                        overflow,
  output logic                        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, level;
  logic          empty, full, hit, push, pop, baud_end;
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Extra pointer bit separates full from empty; level is the pointer distance.
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (PW+1)'(FIFO_DEPTH));
  assign hit      = io_we && (io_addr == IO_ADDR);
  assign push     = hit && !full;
  assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE:  if (!empty) begin
               pop     = 1'b1;
               state_d = START;
             end
      START: if (baud_end) begin
               state_d = DATA;
               bit_d   = '0;
             end
      DATA:  if (baud_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
             end
      STOP:  if (baud_end) begin
               if (!empty) begin
                 pop     = 1'b1;
                 state_d = START;
               end else begin
                 state_d = IDLE;
               end
             end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = mem[rd_ptr[PW-1:0]];
    // tx is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (state_q == IDLE || state_d != state_q || baud_end) baud_q <= '0;
      else                                                  baud_q <= baud_q + CW'(1);
      if (push)        wr_ptr   <= wr_ptr + (PW+1)'(1);
      if (pop)         rd_ptr   <= rd_ptr + (PW+1)'(1);
      if (hit && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= io_wdata;
  end

  assign io_full    = full;
  assign fifo_level = level;
  assign tx_busy    = (state_q != IDLE) || !empty;
  assign tx         = tx_q;

endmodule
